// File: rtl/scratchpad_dma_engine_if.sv
// Command, memory and scratchpad signals of the scratchpad DMA engine.
// master = engine side, slave = command/memory/scratchpad side.
interface scratchpad_dma_engine_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 14
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_dir;
   logic [31:0]           cmd_ext_addr;
   logic [ADDR_WIDTH-1:0] cmd_spad_addr;
   logic [15:0]           cmd_len;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_we;
   logic [31:0]           mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_wdata;
   logic                  mem_rsp_valid;
   logic                  mem_rsp_ready;
   logic [DATA_WIDTH-1:0] mem_rsp_rdata;

   logic                  dma_rd_en;
   logic [ADDR_WIDTH-1:0] dma_rd_addr;
   logic [DATA_WIDTH-1:0] dma_rd_data;
   logic                  dma_rd_valid;
   logic                  dma_wr_en;
   logic [ADDR_WIDTH-1:0] dma_wr_addr;
   logic [DATA_WIDTH-1:0] dma_wr_data;
   logic                  dma_wr_ready;

   logic                  busy;
   logic                  done;

   modport master (
      input  cmd_valid, cmd_dir, cmd_ext_addr, cmd_spad_addr, cmd_len,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  dma_rd_data, dma_rd_valid, dma_wr_ready,
      output cmd_ready,
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      output mem_rsp_ready,
      output dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data,
      output busy, done
   );

   modport slave (
      output cmd_valid, cmd_dir, cmd_ext_addr, cmd_spad_addr, cmd_len,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output dma_rd_data, dma_rd_valid, dma_wr_ready,
      input  cmd_ready,
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      input  mem_rsp_ready,
      input  dma_rd_en, dma_rd_addr, dma_wr_en, dma_wr_addr, dma_wr_data,
      input  busy, done
   );
endinterface

// File: rtl/scratchpad_dma_engine.sv
// Scratchpad DMA engine: pipelined loads (mem->spad) with bounded
// outstanding reads, and one-beat-at-a-time stores (spad->mem).
module scratchpad_dma_engine #(
   parameter int DATA_WIDTH      = 256,
   parameter int ADDR_WIDTH      = 14,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic clk,
   input logic rst_n,
   scratchpad_dma_engine_if.master bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0]   BEAT_BYTES = 32'(DATA_WIDTH / 8);
   localparam logic [OW-1:0] MAX_OUT    = OW'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      IDLE, LOAD, ST_RD, ST_CAP, ST_WR, FIN
   } state_t;

   state_t                state;
   logic [31:0]           ext_addr;
   logic [ADDR_WIDTH-1:0] spad_addr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           req_left;
   logic [15:0]           rsp_left;
   logic [OW-1:0]         outstanding;
   logic [DATA_WIDTH-1:0] hold;
   logic                  cmd_ready_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  rd_en_q;

   logic req_valid;
   logic req_we;
   logic rsp_ready;
   logic req_hs;
   logic rsp_hs;
   logic in_load;

   // Memory-side handshake qualifiers decoded from the current state.
   always_comb begin
      req_valid = 1'b0;
      req_we    = 1'b0;
      rsp_ready = 1'b0;
      unique case (state)
         LOAD: begin
            req_valid = (req_left != 16'd0) && (outstanding < MAX_OUT);
            rsp_ready = bus.dma_wr_ready;
         end
         ST_WR: begin
            req_valid = 1'b1;
            req_we    = 1'b1;
         end
         default: ;
      endcase
   end

   assign req_hs  = req_valid & bus.mem_req_ready;
   assign rsp_hs  = bus.mem_rsp_valid & rsp_ready;
   assign in_load = (state == LOAD);

   // Control FSM with address/beat bookkeeping and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ext_addr    <= '0;
         spad_addr   <= '0;
         wr_addr     <= '0;
         req_left    <= '0;
         rsp_left    <= '0;
         outstanding <= '0;
         hold        <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  ext_addr    <= bus.cmd_ext_addr;
                  spad_addr   <= bus.cmd_spad_addr;
                  wr_addr     <= bus.cmd_spad_addr;
                  req_left    <= bus.cmd_len;
                  rsp_left    <= bus.cmd_len;
                  outstanding <= '0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_len == 16'd0) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                  end else if (bus.cmd_dir) begin
                     state   <= ST_RD;
                     rd_en_q <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (req_hs) begin
                  ext_addr <= ext_addr + BEAT_BYTES;
                  req_left <= req_left - 1'b1;
               end
               if (req_hs && !rsp_hs)
                  outstanding <= outstanding + 1'b1;
               else if (!req_hs && rsp_hs)
                  outstanding <= outstanding - 1'b1;
               if (rsp_hs) begin
                  wr_addr  <= wr_addr + 1'b1;
                  rsp_left <= rsp_left - 1'b1;
                  if (rsp_left == 16'd1) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               state <= ST_CAP;
            end
            ST_CAP: begin
               if (bus.dma_rd_valid) begin
                  hold  <= bus.dma_rd_data;
                  state <= ST_WR;
               end
            end
            ST_WR: begin
               if (bus.mem_req_ready) begin
                  ext_addr  <= ext_addr + BEAT_BYTES;
                  spad_addr <= spad_addr + 1'b1;
                  req_left  <= req_left - 1'b1;
                  if (req_left == 16'd1) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                  end else begin
                     state   <= ST_RD;
                     rd_en_q <= 1'b1;
                  end
               end
            end
            FIN: begin
               state       <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.mem_req_valid = req_valid;
   assign bus.mem_req_we    = req_we;
   assign bus.mem_req_addr  = ext_addr;
   assign bus.mem_req_wdata = hold;
   assign bus.mem_rsp_ready = rsp_ready;
   assign bus.dma_rd_en     = rd_en_q;
   assign bus.dma_rd_addr   = spad_addr;
   assign bus.dma_wr_en     = in_load & bus.mem_rsp_valid & bus.dma_wr_ready;
   assign bus.dma_wr_addr   = wr_addr;
   assign bus.dma_wr_data   = in_load ? bus.mem_rsp_rdata : '0;
endmodule

// File: tb/tb_scratchpad_dma_engine.sv
// Randomized bench for scratchpad_dma_engine: environment models for
// memory and scratchpad, transfer logs checked against expected beats.
module tb_scratchpad_dma_engine;
   localparam int DW  = 256;
   localparam int AW  = 14;
   localparam int MO  = 4;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scratchpad_dma_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   scratchpad_dma_engine #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [31:0] salt;

   logic [31:0]   req_q[$];
   logic [31:0]   mwa_q[$];
   logic [DW-1:0] mwd_q[$];
   logic [AW-1:0] srd_q[$];
   logic [AW-1:0] swa_q[$];
   logic [DW-1:0] swd_q[$];
   logic [31:0]   pend_a[$];
   int            pend_t[$];

   int done_cnt = 0;
   int done_cyc = 0;
   int mw_cyc = 0;
   bit prev_done = 0;
   int out_cnt = 0;
   bit prev_wait = 0;
   logic [31:0] prev_addr;
   logic prev_we;
   bit rd_pend = 0;
   logic [AW-1:0] rd_addr_l;

   bit rnd_req = 0;
   bit rnd_wr = 0;
   int stall_req = 0;
   int stall_at = 0;
   int stall_wr = 0;
   int stall_wr_at = 0;

   function automatic logic [DW-1:0] mem_fn(input logic [31:0] a);
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++)
         v[k*32 +: 32] = (a ^ salt) + 32'(k) * 32'h0101_0101;
      return v;
   endfunction

   function automatic logic [DW-1:0] spad_fn(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++)
         v[k*32 +: 32] = ((32'(a) << 4) + 32'(k)) ^ ~salt;
      return v;
   endfunction

   function automatic logic [7:0] ctl_snap();
      return {bus.cmd_ready, bus.busy, bus.done, bus.mem_req_valid,
              bus.mem_req_we, bus.mem_rsp_ready, bus.dma_rd_en,
              bus.dma_wr_en};
   endfunction

   // Environment: memory with fixed read latency, scratchpad with
   // one-cycle read data, plus cycle-level protocol invariants.
   initial begin
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      bus.dma_rd_valid  = 1'b0;
      bus.dma_rd_data   = '0;
      bus.dma_wr_ready  = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_a.delete();
            pend_t.delete();
            rd_pend   = 0;
            out_cnt   = 0;
            prev_wait = 0;
            prev_done = 0;
         end else begin
            if (prev_wait) begin
               tests++;
               if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr ||
                   bus.mem_req_we !== prev_we) begin
                  fails++;
                  $display("FAIL req_hold: valid=%b addr=%h we=%b, required valid=1 addr=%h we=%b",
                           bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we,
                           prev_addr, prev_we);
               end
            end
            prev_wait = bus.mem_req_valid && !bus.mem_req_ready;
            prev_addr = bus.mem_req_addr;
            prev_we   = bus.mem_req_we;
            if (bus.busy) begin
               tests++;
               if (bus.cmd_ready !== 1'b0) begin
                  fails++;
                  $display("FAIL cmd_ready_busy: cmd_ready=%b, required 0", bus.cmd_ready);
               end
            end
            if (!bus.dma_wr_ready) begin
               tests++;
               if (bus.mem_rsp_ready !== 1'b0 || bus.dma_wr_en !== 1'b0) begin
                  fails++;
                  $display("FAIL wr_backpressure: rsp_ready=%b wr_en=%b, required 0 0",
                           bus.mem_rsp_ready, bus.dma_wr_en);
               end
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               if (bus.mem_req_we) begin
                  mwa_q.push_back(bus.mem_req_addr);
                  mwd_q.push_back(bus.mem_req_wdata);
                  mw_cyc = cyc;
               end else begin
                  req_q.push_back(bus.mem_req_addr);
                  pend_a.push_back(bus.mem_req_addr);
                  pend_t.push_back(cyc + LAT);
                  out_cnt++;
                  tests++;
                  if (out_cnt > MO) begin
                     fails++;
                     $display("FAIL outstanding: %0d in flight, required <= %0d", out_cnt, MO);
                  end
               end
            end
            if (bus.mem_rsp_valid && bus.mem_rsp_ready && pend_a.size() > 0) begin
               void'(pend_a.pop_front());
               void'(pend_t.pop_front());
               out_cnt--;
            end
            if (stall_req > 0 && bus.mem_req_valid && !bus.mem_req_ready)
               stall_req--;
            if (stall_wr > 0 && !bus.dma_wr_ready)
               stall_wr--;
            if (bus.dma_rd_en) begin
               srd_q.push_back(bus.dma_rd_addr);
               rd_pend   = 1;
               rd_addr_l = bus.dma_rd_addr;
            end
            if (bus.dma_wr_en) begin
               swa_q.push_back(bus.dma_wr_addr);
               swd_q.push_back(bus.dma_wr_data);
            end
            if (bus.done) begin
               done_cnt++;
               done_cyc = cyc;
               tests++;
               if (prev_done) begin
                  fails++;
                  $display("FAIL done_pulse: done high 2 cycles, required 1-cycle pulse");
               end
            end
            prev_done = bus.done;
         end
         @(posedge clk);
         #1;
         cyc++;
         bus.mem_req_ready = rnd_req ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall_req > 0 && req_q.size() == stall_at)
            bus.mem_req_ready = 1'b0;
         if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = mem_fn(pend_a[0]);
         end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = {8{$urandom}};
         end
         bus.dma_rd_valid = rd_pend;
         bus.dma_rd_data  = rd_pend ? spad_fn(rd_addr_l) : {8{$urandom}};
         rd_pend = 0;
         bus.dma_wr_ready = rnd_wr ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall_wr > 0 && swa_q.size() == stall_wr_at)
            bus.dma_wr_ready = 1'b0;
      end
   end

   task automatic clear_logs();
      req_q.delete();
      mwa_q.delete();
      mwd_q.delete();
      srd_q.delete();
      swa_q.delete();
      swd_q.delete();
      done_cnt = 0;
   endtask

   task automatic run_cmd(input logic dir, input logic [31:0] ext,
                          input logic [AW-1:0] sp, input logic [15:0] len);
      int n;
      @(posedge clk);
      #1;
      clear_logs();
      bus.cmd_valid     = 1'b1;
      bus.cmd_dir       = dir;
      bus.cmd_ext_addr  = ext;
      bus.cmd_spad_addr = sp;
      bus.cmd_len       = len;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.cmd_ready !== 1'b1 && n < 20);
      @(posedge clk);
      #1;
      bus.cmd_valid    = 1'b0;
      bus.cmd_dir      = 1'($urandom);
      bus.cmd_ext_addr = $urandom;
      bus.cmd_len      = 16'($urandom);
      n = 0;
      while (done_cnt == 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      tests++;
      if (done_cnt !== 1) begin
         fails++;
         $display("FAIL done_count: %0d done pulses, required 1", done_cnt);
      end
   endtask

   task automatic check_load(input logic [31:0] ext, input logic [AW-1:0] sp,
                             input int len);
      logic [31:0] ea;
      logic [AW-1:0] sa;
      tests++;
      if (req_q.size() != len || swa_q.size() != len) begin
         fails++;
         $display("FAIL load_count: reqs=%0d writes=%0d, required %0d",
                  req_q.size(), swa_q.size(), len);
      end
      tests++;
      if (mwa_q.size() != 0 || srd_q.size() != 0) begin
         fails++;
         $display("FAIL load_stray: mem writes=%0d spad reads=%0d, required 0",
                  mwa_q.size(), srd_q.size());
      end
      for (int i = 0; i < len; i++) begin
         ea = ext + 32'(i) * 32'd32;
         sa = sp + AW'(i);
         if (i < req_q.size()) begin
            tests++;
            if (req_q[i] !== ea) begin
               fails++;
               $display("FAIL load_req_addr[%0d]: %h, required %h", i, req_q[i], ea);
            end
         end
         if (i < swa_q.size()) begin
            tests++;
            if (swa_q[i] !== sa || swd_q[i] !== mem_fn(ea)) begin
               fails++;
               $display("FAIL load_spad_wr[%0d]: addr=%h data=%h, required addr=%h data=%h",
                        i, swa_q[i], swd_q[i], sa, mem_fn(ea));
            end
         end
      end
   endtask

   task automatic check_store(input logic [31:0] ext, input logic [AW-1:0] sp,
                              input int len);
      logic [31:0] ea;
      logic [AW-1:0] sa;
      tests++;
      if (srd_q.size() != len || mwa_q.size() != len) begin
         fails++;
         $display("FAIL store_count: spad reads=%0d mem writes=%0d, required %0d",
                  srd_q.size(), mwa_q.size(), len);
      end
      tests++;
      if (req_q.size() != 0 || swa_q.size() != 0) begin
         fails++;
         $display("FAIL store_stray: mem reads=%0d spad writes=%0d, required 0",
                  req_q.size(), swa_q.size());
      end
      for (int i = 0; i < len; i++) begin
         ea = ext + 32'(i) * 32'd32;
         sa = sp + AW'(i);
         if (i < srd_q.size()) begin
            tests++;
            if (srd_q[i] !== sa) begin
               fails++;
               $display("FAIL store_spad_rd[%0d]: %h, required %h", i, srd_q[i], sa);
            end
         end
         if (i < mwa_q.size()) begin
            tests++;
            if (mwa_q[i] !== ea || mwd_q[i] !== spad_fn(sa)) begin
               fails++;
               $display("FAIL store_mem_wr[%0d]: addr=%h data=%h, required addr=%h data=%h",
                        i, mwa_q[i], mwd_q[i], ea, spad_fn(sa));
            end
         end
      end
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (ctl_snap() !== 8'b1000_0000) begin
         fails++;
         $display("FAIL reset_ctl: %b, required 10000000", ctl_snap());
      end
      tests++;
      if ({bus.mem_req_addr, bus.mem_req_wdata, bus.dma_rd_addr,
           bus.dma_wr_addr, bus.dma_wr_data} !== '0) begin
         fails++;
         $display("FAIL reset_data: addr=%h rd=%h wr=%h, required all 0",
                  bus.mem_req_addr, bus.dma_rd_addr, bus.dma_wr_addr);
      end
      bus.cmd_valid = 1'b0;
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0",
                  bus.cmd_ready, bus.busy);
      end
   endtask

   task automatic test_load_basic();
      run_cmd(1'b0, 32'h1000, 14'h10, 16'd8);
      check_load(32'h1000, 14'h10, 8);
   endtask

   task automatic test_store_wrap();
      run_cmd(1'b1, 32'h2000, 14'h3FFE, 16'd3);
      check_store(32'h2000, 14'h3FFE, 3);
      tests++;
      if (done_cyc !== mw_cyc + 1) begin
         fails++;
         $display("FAIL store_done_timing: done cycle %0d, required %0d", done_cyc, mw_cyc + 1);
      end
   endtask

   task automatic test_load_stalls();
      logic [31:0] ext;
      logic [AW-1:0] sp;
      ext = $urandom & 32'hFFFF_FFE0;
      sp = AW'($urandom);
      stall_at = 1;
      stall_req = 5;
      stall_wr_at = 3;
      stall_wr = 3;
      run_cmd(1'b0, ext, sp, 16'd8);
      check_load(ext, sp, 8);
      tests++;
      if (stall_req != 0 || stall_wr != 0) begin
         fails++;
         $display("FAIL stall_applied: req stalls left=%0d wr stalls left=%0d, required 0 0",
                  stall_req, stall_wr);
      end
      stall_req = 0;
      stall_wr = 0;
   endtask

   task automatic test_zero_len();
      int n;
      int dk;
      logic rdy[1:5];
      @(posedge clk);
      #1;
      clear_logs();
      bus.cmd_valid     = 1'b1;
      bus.cmd_dir       = 1'($urandom);
      bus.cmd_ext_addr  = $urandom;
      bus.cmd_spad_addr = AW'($urandom);
      bus.cmd_len       = 16'd0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.cmd_ready !== 1'b1 && n < 20);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      dk = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         rdy[k] = bus.cmd_ready;
         if (bus.done === 1'b1 && dk == 0)
            dk = k;
      end
      tests++;
      if (dk < 1 || dk > 2 || rdy[dk+1] !== 1'b1) begin
         fails++;
         $display("FAIL zero_len_timing: done at cycle %0d after accept, required 1..2 with cmd_ready next",
                  dk);
      end
      tests++;
      if (done_cnt !== 1) begin
         fails++;
         $display("FAIL zero_len_done: %0d pulses, required 1", done_cnt);
      end
      tests++;
      if (req_q.size() + mwa_q.size() + srd_q.size() + swa_q.size() != 0) begin
         fails++;
         $display("FAIL zero_len_activity: %0d transfers, required 0",
                  req_q.size() + mwa_q.size() + srd_q.size() + swa_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int n;
      logic [31:0] ext;
      logic [AW-1:0] sp;
      @(posedge clk);
      #1;
      clear_logs();
      bus.cmd_valid     = 1'b1;
      bus.cmd_dir       = 1'b0;
      bus.cmd_ext_addr  = 32'h4000;
      bus.cmd_spad_addr = 14'h100;
      bus.cmd_len       = 16'd8;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (swa_q.size() < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (ctl_snap() !== 8'b1000_0000) begin
         fails++;
         $display("FAIL midreset_ctl: %b after %0d beats, required 10000000",
                  ctl_snap(), swa_q.size());
      end
      tests++;
      if ({bus.mem_req_addr, bus.mem_req_wdata, bus.dma_rd_addr,
           bus.dma_wr_addr, bus.dma_wr_data} !== '0) begin
         fails++;
         $display("FAIL midreset_data: addr=%h wr_addr=%h, required 0",
                  bus.mem_req_addr, bus.dma_wr_addr);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      tests++;
      if (done_cnt !== 0) begin
         fails++;
         $display("FAIL midreset_done: %0d pulses, required 0", done_cnt);
      end
      ext = $urandom & 32'hFFFF_FFE0;
      sp = AW'($urandom);
      run_cmd(1'b0, ext, sp, 16'd8);
      check_load(ext, sp, 8);
   endtask

   task automatic test_random();
      logic dir;
      logic [31:0] ext;
      logic [AW-1:0] sp;
      int len;
      for (int it = 0; it < 12; it++) begin
         rnd_req = 1'($urandom);
         rnd_wr = 1'($urandom);
         dir = 1'($urandom);
         len = $urandom_range(1, 12);
         ext = (it % 4 == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFE0);
         sp = (it % 3 == 0) ? 14'h3FFA : AW'($urandom);
         run_cmd(dir, ext, sp, 16'(len));
         if (dir)
            check_store(ext, sp, len);
         else
            check_load(ext, sp, len);
      end
      rnd_req = 0;
      rnd_wr = 0;
   endtask

   initial begin
      salt = $urandom;
      bus.cmd_valid     = 1'b0;
      bus.cmd_dir       = 1'b0;
      bus.cmd_ext_addr  = '0;
      bus.cmd_spad_addr = '0;
      bus.cmd_len       = '0;
      test_reset();
      test_load_basic();
      test_store_wrap();
      test_load_stalls();
      test_zero_len();
      test_reset_mid_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
